// File: rtl/sid_mix_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed SID voice mixer.
// Helpers work on 32-bit values; callers size-cast the result to their own width.
package sid_mix_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_PRE,
      S_WAIT_FILT,
      S_POST,
      S_VOL
   } state_t;

   // Master volume is 4 bits, so full scale is a divide by 16.
   localparam int VOL_SHIFT = 4;

   // Clamp x to the signed range of an out_w-bit word.
   function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int out_w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   // Offset-binary w-bit oscillator word to sign-extended two's complement.
   function automatic logic signed [31:0] to_signed(input logic [31:0] v, input int w);
      logic [31:0] flipped;
      flipped = v ^ (32'd1 << (w - 1));
      return $signed(flipped << (32 - w)) >>> (32 - w);
   endfunction

endpackage

// File: rtl/sid_mix_mac.sv
// Registered signed x unsigned multiplier with a run-time arithmetic output shift.
// Shared by the per-voice envelope scaling and the master-volume stage.
module sid_mix_mac #(
   parameter int A_W  = 16,
   parameter int B_W  = 8,
   parameter int SH_W = 6,
   parameter int P_W  = A_W + B_W + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic signed [A_W-1:0]  a,
   input  logic [B_W-1:0]         b,
   input  logic [SH_W-1:0]        shift,
   output logic signed [P_W-1:0]  p
);

   logic signed [P_W-1:0] a_x;
   logic signed [P_W-1:0] b_x;
   logic signed [P_W-1:0] prod;

   // b is unsigned: a zero sign bit keeps the signed multiply exact.
   always_comb begin
      a_x  = P_W'(a);
      b_x  = P_W'($signed({1'b0, b}));
      prod = a_x * b_x;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p <= '0;
      end else if (en) begin
         p <= prod >>> shift;
      end
   end

endmodule

// File: rtl/sid_mix_seq.sv
// N-voice SID mixer: envelope scaling through one shared multiplier, filter-feed and
// bypass sums, filter handshake, mode select, saturation and master volume.
module sid_mix_seq
   import sid_mix_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int VOICE_W    = 12,
   parameter int ENV_W      = 8,
   parameter int OUT_W      = 16,
   parameter int HEADROOM   = 3
) (
   input  logic                          clk,
   input  logic                          iRstN,
   input  logic                          clkEn,
   input  logic [NUM_VOICES*VOICE_W-1:0] iVoice,
   input  logic [NUM_VOICES*ENV_W-1:0]   iEnv,
   input  logic [NUM_VOICES-1:0]         iFiltMask,
   input  logic [2:0]                    iMode,
   input  logic [3:0]                    iVolume,
   input  logic signed [OUT_W-1:0]       iFiltLP,
   input  logic signed [OUT_W-1:0]       iFiltBP,
   input  logic signed [OUT_W-1:0]       iFiltHP,
   input  logic                          iFiltValid,
   output logic signed [OUT_W-1:0]       oPreFilter,
   output logic                          oPreValid,
   output logic signed [OUT_W-1:0]       oOut,
   output logic                          oOutValid,
   output logic                          oClip,
   output logic                          oOverrun,
   output logic                          oBusy
);

   localparam int IDX_W  = $clog2(NUM_VOICES + 1);
   localparam int ACC_W  = OUT_W + $clog2(NUM_VOICES) + 1;
   localparam int SUM_W  = OUT_W + 2;
   localparam int VSHIFT = VOICE_W + ENV_W - OUT_W;
   localparam int A_W    = (OUT_W > VOICE_W) ? OUT_W : VOICE_W;
   localparam int B_W    = (ENV_W > 4) ? ENV_W : 4;
   localparam int SH_W   = 6;
   localparam int P_W    = A_W + B_W + 1;

   state_t state, state_next;

   logic [NUM_VOICES*VOICE_W-1:0] voice_q;
   logic [NUM_VOICES*ENV_W-1:0]   env_q;
   logic [NUM_VOICES-1:0]         mask_q;
   logic [2:0]                    mode_q;
   logic [3:0]                    vol_q;
   logic [IDX_W-1:0]              idx;
   logic                          acc_mask;
   logic                          vol_phase;
   logic signed [ACC_W-1:0]       acc_pre;
   logic signed [ACC_W-1:0]       acc_byp;
   logic signed [OUT_W-1:0]       lp_q, bp_q, hp_q;
   logic signed [OUT_W-1:0]       sat_sum;
   logic                          clip_q;

   logic [VOICE_W-1:0]            voice_sel;
   logic [ENV_W-1:0]              env_sel;
   logic                          mask_sel;
   logic signed [VOICE_W-1:0]     voice_s;
   logic                          mac_en;
   logic signed [A_W-1:0]         mac_a;
   logic [B_W-1:0]                mac_b;
   logic [SH_W-1:0]               mac_shift;
   logic signed [P_W-1:0]         mac_p;
   logic signed [OUT_W-1:0]       amp;
   logic signed [OUT_W-1:0]       amp_h;
   logic signed [OUT_W-1:0]       pre_sat;
   logic signed [OUT_W-1:0]       byp_sat;
   logic signed [SUM_W-1:0]       post_sum;
   logic signed [31:0]            post_s32;
   logic signed [OUT_W-1:0]       post_sat;
   logic                          post_clip;

   // NOTE: every always_comb output gets a default before any branch, so no
   // path can leave a value held and infer a latch.
   always_comb begin
      voice_sel = '0;
      env_sel   = '0;
      mask_sel  = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (idx == IDX_W'(i)) begin
            voice_sel = voice_q[i*VOICE_W +: VOICE_W];
            env_sel   = env_q[i*ENV_W +: ENV_W];
            mask_sel  = mask_q[i];
         end
      end
   end

   // One multiplier: voices during MAC, saturated sum x volume during VOL.
   always_comb begin
      voice_s   = VOICE_W'(to_signed(32'(voice_sel), VOICE_W));
      mac_en    = ((state == S_MAC) && (idx < IDX_W'(NUM_VOICES))) ||
                  ((state == S_VOL) && !vol_phase);
      mac_a     = (state == S_VOL) ? A_W'(sat_sum) : A_W'(voice_s);
      mac_b     = (state == S_VOL) ? B_W'(vol_q) : B_W'(env_sel);
      mac_shift = (state == S_VOL) ? SH_W'(VOL_SHIFT) : SH_W'(VSHIFT);
   end

   sid_mix_mac #(
      .A_W  (A_W),
      .B_W  (B_W),
      .SH_W (SH_W),
      .P_W  (P_W)
   ) u_mac (
      .clk   (clk),
      .rst_n (iRstN),
      .en    (mac_en),
      .a     (mac_a),
      .b     (mac_b),
      .shift (mac_shift),
      .p     (mac_p)
   );

   // amp is the voice amplitude in MAC and the scaled output sample in VOL.
   always_comb begin
      amp       = OUT_W'(mac_p);
      amp_h     = amp >>> HEADROOM;
      pre_sat   = OUT_W'(sat(32'(acc_pre), OUT_W));
      byp_sat   = OUT_W'(sat(32'(acc_byp), OUT_W));
      post_sum  = SUM_W'(byp_sat) + SUM_W'(lp_q) + SUM_W'(bp_q) + SUM_W'(hp_q);
      post_s32  = sat(32'(post_sum), OUT_W);
      post_sat  = OUT_W'(post_s32);
      post_clip = (post_s32 != 32'(post_sum));
   end

   always_ff @(posedge clk or negedge iRstN) begin
      if (!iRstN) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (clkEn) state_next = S_MAC;
         S_MAC:       if (idx == IDX_W'(NUM_VOICES)) state_next = S_PRE;
         S_PRE:       state_next = S_WAIT_FILT;
         S_WAIT_FILT: if (iFiltValid) state_next = S_POST;
         S_POST:      state_next = S_VOL;
         S_VOL:       if (vol_phase) state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   assign oBusy = (state != S_IDLE);

   always_ff @(posedge clk or negedge iRstN) begin
      if (!iRstN) begin
         voice_q    <= '0;
         env_q      <= '0;
         mask_q     <= '0;
         mode_q     <= '0;
         vol_q      <= '0;
         idx        <= '0;
         acc_mask   <= 1'b0;
         vol_phase  <= 1'b0;
         acc_pre    <= '0;
         acc_byp    <= '0;
         lp_q       <= '0;
         bp_q       <= '0;
         hp_q       <= '0;
         sat_sum    <= '0;
         clip_q     <= 1'b0;
         oPreFilter <= '0;
         oPreValid  <= 1'b0;
         oOut       <= '0;
         oOutValid  <= 1'b0;
         oClip      <= 1'b0;
         oOverrun   <= 1'b0;
      end else begin
         oPreValid <= 1'b0;
         oOutValid <= 1'b0;
         oClip     <= 1'b0;
         if (clkEn && (state != S_IDLE)) oOverrun <= 1'b1;

         case (state)
            S_IDLE: begin
               if (clkEn) begin
                  voice_q   <= iVoice;
                  env_q     <= iEnv;
                  mask_q    <= iFiltMask;
                  mode_q    <= iMode;
                  vol_q     <= iVolume;
                  acc_pre   <= '0;
                  acc_byp   <= '0;
                  idx       <= '0;
                  vol_phase <= 1'b0;
               end
            end
            // The product issued at idx-1 lands in mac_p while idx is issued.
            S_MAC: begin
               idx      <= idx + 1'b1;
               acc_mask <= mask_sel;
               if (idx != '0) begin
                  if (acc_mask) acc_pre <= acc_pre + ACC_W'(amp_h);
                  else          acc_byp <= acc_byp + ACC_W'(amp_h);
               end
            end
            S_PRE: begin
               oPreFilter <= pre_sat;
               oPreValid  <= 1'b1;
            end
            S_WAIT_FILT: begin
               if (iFiltValid) begin
                  lp_q <= mode_q[0] ? iFiltLP : '0;
                  bp_q <= mode_q[1] ? iFiltBP : '0;
                  hp_q <= mode_q[2] ? iFiltHP : '0;
               end
            end
            S_POST: begin
               sat_sum <= post_sat;
               clip_q  <= post_clip;
            end
            S_VOL: begin
               vol_phase <= 1'b1;
               if (vol_phase) begin
                  oOut      <= amp;
                  oOutValid <= 1'b1;
                  oClip     <= clip_q;
                  vol_phase <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sid_mix_seq.sv
// Directed bench for sid_mix_seq with hand-computed samples for the default 3-voice setup.
module tb_sid_mix_seq;

   logic               clk;
   logic               iRstN;
   logic               clkEn;
   logic [35:0]        iVoice;
   logic [23:0]        iEnv;
   logic [2:0]         iFiltMask;
   logic [2:0]         iMode;
   logic [3:0]         iVolume;
   logic signed [15:0] iFiltLP, iFiltBP, iFiltHP;
   logic               iFiltValid;
   logic signed [15:0] oPreFilter;
   logic               oPreValid;
   logic signed [15:0] oOut;
   logic               oOutValid;
   logic               oClip;
   logic               oOverrun;
   logic               oBusy;

   int errors = 0;
   int checks = 0;

   sid_mix_seq dut (
      .clk        (clk),
      .iRstN      (iRstN),
      .clkEn      (clkEn),
      .iVoice     (iVoice),
      .iEnv       (iEnv),
      .iFiltMask  (iFiltMask),
      .iMode      (iMode),
      .iVolume    (iVolume),
      .iFiltLP    (iFiltLP),
      .iFiltBP    (iFiltBP),
      .iFiltHP    (iFiltHP),
      .iFiltValid (iFiltValid),
      .oPreFilter (oPreFilter),
      .oPreValid  (oPreValid),
      .oOut       (oOut),
      .oOutValid  (oOutValid),
      .oClip      (oClip),
      .oOverrun   (oOverrun),
      .oBusy      (oBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one full sample; latencies count rising edges after the strobe / filter-valid edge.
   task automatic do_sample(input logic [35:0] voice, input logic [23:0] env,
                            input logic [2:0] mask, input logic [2:0] mode, input logic [3:0] vol,
                            input logic signed [15:0] lp, input logic signed [15:0] bp,
                            input logic signed [15:0] hp,
                            output int pre_lat, output int out_lat,
                            output logic signed [15:0] pre_v, output logic signed [15:0] out_v,
                            output logic clip_v);
      @(negedge clk);
      iVoice = voice; iEnv = env; iFiltMask = mask; iMode = mode; iVolume = vol;
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
      pre_lat = 0;
      while (!oPreValid && pre_lat < 40) begin @(negedge clk); pre_lat++; end
      pre_v = oPreFilter;
      iFiltLP = lp; iFiltBP = bp; iFiltHP = hp; iFiltValid = 1'b1;
      @(negedge clk);
      iFiltValid = 1'b0;
      out_lat = 0;
      while (!oOutValid && out_lat < 40) begin @(negedge clk); out_lat++; end
      out_v  = oOut;
      clip_v = oClip;
      @(negedge clk);
   endtask

   task automatic test_reset();
      iRstN = 1'b0; clkEn = 1'b0; iFiltValid = 1'b0;
      iVoice = '0; iEnv = '0; iFiltMask = '0; iMode = '0; iVolume = '0;
      iFiltLP = '0; iFiltBP = '0; iFiltHP = '0;
      #12;
      checks++;
      if ({oPreFilter, oPreValid, oOut, oOutValid, oClip, oOverrun, oBusy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got pre=%0d out=%0d flags=%b required all zero",
                  oPreFilter, oOut, {oPreValid, oOutValid, oClip, oOverrun, oBusy});
      end
      @(negedge clk);
      iRstN = 1'b1;
      @(negedge clk);
      checks++;
      if (oBusy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", oBusy); end
   endtask

   task automatic test_bypass();
      int pl, ol; logic signed [15:0] pv, ov; logic cv;
      // LP is presented but mode 000 must ignore it.
      do_sample(36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b000, 3'b000, 4'd15, 16'sd20000, 16'sd0, 16'sd0,
                pl, ol, pv, ov, cv);
      checks++; if (pl !== 5) begin errors++; $display("FAIL bypass_pre_latency: got %0d required 5", pl); end
      checks++; if (pv !== 16'sd0) begin errors++; $display("FAIL bypass_pre: got %0d required 0", pv); end
      checks++; if (ov !== 16'sd11469) begin errors++; $display("FAIL bypass_out: got %0d required 11469", ov); end
      checks++; if (cv !== 1'b0) begin errors++; $display("FAIL bypass_clip: got %b required 0", cv); end
      checks++; if (oOutValid !== 1'b0 || oBusy !== 1'b0) begin
         errors++; $display("FAIL bypass_pulse_end: got valid=%b busy=%b required 0 0", oOutValid, oBusy);
      end
   endtask

   task automatic test_filter_lp();
      int pl, ol; logic signed [15:0] pv, ov; logic cv;
      do_sample(36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b111, 3'b001, 4'd15, 16'sd20000, 16'sd10000, 16'sd5000,
                pl, ol, pv, ov, cv);
      checks++; if (pv !== 16'sd12234) begin errors++; $display("FAIL lp_pre: got %0d required 12234", pv); end
      checks++; if (ol !== 3) begin errors++; $display("FAIL lp_out_latency: got %0d required 3", ol); end
      checks++; if (ov !== 16'sd18750) begin errors++; $display("FAIL lp_out: got %0d required 18750", ov); end
      checks++; if (cv !== 1'b0) begin errors++; $display("FAIL lp_clip: got %b required 0", cv); end
   endtask

   task automatic test_negative();
      int pl, ol; logic signed [15:0] pv, ov; logic cv;
      do_sample(36'h000_000_000, 24'hFF_FF_FF, 3'b000, 3'b000, 4'd15, 16'sd0, 16'sd0, 16'sd0,
                pl, ol, pv, ov, cv);
      checks++; if (ov !== -16'sd11475) begin errors++; $display("FAIL neg_out: got %0d required -11475", ov); end
      // bypass -12240 plus BP -20000 plus HP -10000 clamps to -32768.
      do_sample(36'h000_000_000, 24'hFF_FF_FF, 3'b000, 3'b110, 4'd15, 16'sd30000, -16'sd20000, -16'sd10000,
                pl, ol, pv, ov, cv);
      checks++; if (ov !== -16'sd30720) begin errors++; $display("FAIL neg_clip_out: got %0d required -30720", ov); end
      checks++; if (cv !== 1'b1) begin errors++; $display("FAIL neg_clip_flag: got %b required 1", cv); end
   endtask

   task automatic test_clip();
      int pl, ol; logic signed [15:0] pv, ov; logic cv;
      do_sample(36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b000, 3'b011, 4'd15, 16'sd20000, 16'sd10000, 16'sd0,
                pl, ol, pv, ov, cv);
      checks++; if (ov !== 16'sd30719) begin errors++; $display("FAIL clip_out: got %0d required 30719", ov); end
      checks++; if (cv !== 1'b1) begin errors++; $display("FAIL clip_flag: got %b required 1", cv); end
      do_sample(36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b000, 3'b000, 4'd0, 16'sd0, 16'sd0, 16'sd0,
                pl, ol, pv, ov, cv);
      checks++; if (ov !== 16'sd0) begin errors++; $display("FAIL vol_zero_out: got %0d required 0", ov); end
   endtask

   task automatic test_overrun();
      int cnt, extra, pl, ol; logic signed [15:0] pv, ov; logic cv;
      @(negedge clk);
      iVoice = 36'hFFF_FFF_FFF; iEnv = 24'hFF_FF_FF; iFiltMask = 3'b111; iMode = 3'b001; iVolume = 4'd15;
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
      iFiltLP = -16'sd30000; iFiltValid = 1'b1;   // during MAC: must be ignored
      @(negedge clk);
      iFiltValid = 1'b0; iFiltLP = 16'sd20000;
      cnt = 1;
      while (!oPreValid && cnt < 40) begin @(negedge clk); cnt++; end
      checks++; if (cnt !== 5) begin errors++; $display("FAIL ovr_pre_latency: got %0d required 5", cnt); end
      checks++; if (oPreFilter !== 16'sd12234) begin errors++; $display("FAIL ovr_pre: got %0d required 12234", oPreFilter); end
      clkEn = 1'b1; iVolume = 4'd0; iVoice = '0;
      @(negedge clk);
      clkEn = 1'b0;
      checks++; if (oOverrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b required 1", oOverrun); end
      iFiltValid = 1'b1;
      @(negedge clk);
      iFiltValid = 1'b0;
      cnt = 0;
      while (!oOutValid && cnt < 40) begin @(negedge clk); cnt++; end
      checks++; if (oOut !== 16'sd18750) begin errors++; $display("FAIL ovr_out: got %0d required 18750", oOut); end
      extra = 0;
      repeat (15) begin @(negedge clk); if (oOutValid || oBusy) extra++; end
      checks++; if (extra !== 0) begin errors++; $display("FAIL ovr_no_second: got %0d busy/valid cycles required 0", extra); end
      do_sample(36'h000_000_000, 24'hFF_FF_FF, 3'b000, 3'b000, 4'd15, 16'sd0, 16'sd0, 16'sd0,
                pl, ol, pv, ov, cv);
      checks++; if (ov !== -16'sd11475) begin errors++; $display("FAIL ovr_next_out: got %0d required -11475", ov); end
      checks++; if (oOverrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b required 1", oOverrun); end
   endtask

   task automatic test_reset_mid_mac();
      int pl, ol; logic signed [15:0] pv, ov; logic cv;
      @(negedge clk);
      iVoice = 36'hFFF_FFF_FFF; iEnv = 24'hFF_FF_FF; iFiltMask = 3'b111; iMode = 3'b001; iVolume = 4'd15;
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
      @(negedge clk);
      iRstN = 1'b0;
      #1;
      checks++;
      if ({oPreFilter, oPreValid, oOut, oOutValid, oClip, oOverrun, oBusy} !== '0) begin
         errors++;
         $display("FAIL midmac_reset: got pre=%0d out=%0d flags=%b required all zero",
                  oPreFilter, oOut, {oPreValid, oOutValid, oClip, oOverrun, oBusy});
      end
      @(negedge clk);
      iRstN = 1'b1;
      do_sample(36'hFFF_FFF_FFF, 24'hFF_FF_FF, 3'b000, 3'b000, 4'd15, 16'sd0, 16'sd0, 16'sd0,
                pl, ol, pv, ov, cv);
      checks++; if (ov !== 16'sd11469) begin errors++; $display("FAIL midmac_rerun_out: got %0d required 11469", ov); end
      checks++; if (pv !== 16'sd0) begin errors++; $display("FAIL midmac_rerun_pre: got %0d required 0", pv); end
   endtask

   task automatic test_back_to_back();
      int cnt, extra;
      checks++; if (oOverrun !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b required 0", oOverrun); end
      @(negedge clk);
      iVoice = 36'hFFF_FFF_FFF; iEnv = 24'hFF_FF_FF; iFiltMask = 3'b000; iMode = 3'b000; iVolume = 4'd15;
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
      cnt = 0;
      while (!oPreValid && cnt < 40) begin @(negedge clk); cnt++; end
      iFiltValid = 1'b1;
      @(negedge clk);
      iFiltValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clkEn = 1'b1;                              // coincides with the return to IDLE
      @(negedge clk);
      clkEn = 1'b0;
      checks++; if (oOutValid !== 1'b1 || oOut !== 16'sd11469) begin
         errors++; $display("FAIL b2b_out: got valid=%b out=%0d required 1 11469", oOutValid, oOut);
      end
      checks++; if (oOverrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b required 1", oOverrun); end
      extra = 0;
      repeat (10) begin @(negedge clk); if (oBusy) extra++; end
      checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_ignored: got %0d busy cycles required 0", extra); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_filter_lp();
      test_negative();
      test_clip();
      test_overrun();
      test_reset_mid_mac();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
